// File: rtl/auto_threshold_ctrl.sv
// auto_threshold_ctrl: per-frame binarisation threshold controller.
// It tracks the min/max intensity of each frame and, at end of frame, loads
// threshold = midpoint(min, max) for use on the next frame.
// Optional build macro THRESH_SMOOTH_EN: the new threshold becomes
// (threshold + midpoint) >> 1, an IIR blend with the previous value.
module auto_threshold_ctrl #(
    parameter int unsigned     WIDTH          = 8,
    parameter int unsigned     FRAME_W        = 640,
    parameter int unsigned     FRAME_H        = 480,
    parameter logic [WIDTH-1:0] INIT_THRESHOLD = WIDTH'(128)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_i,
    output logic             busy,
    output logic [WIDTH-1:0] threshold,
    output logic             thr_valid,
    output logic [WIDTH-1:0] stat_min,
    output logic [WIDTH-1:0] stat_max
);

    localparam int unsigned PIXELS = FRAME_W * FRAME_H;
    localparam int unsigned CNT_W  = (PIXELS > 1) ? $clog2(PIXELS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PIXELS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        UPDATE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] run_min;
    logic [WIDTH-1:0] run_max;
    logic             beat;
    logic             last_beat;
    logic [WIDTH:0]   mid_sum;
    logic [WIDTH-1:0] mid;
    logic [WIDTH-1:0] thr_new;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; start is only honoured in IDLE
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = ACCUM;
            ACCUM:   if (last_beat) state_next = UPDATE;
            UPDATE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM-decoded handshake and status outputs
    always_comb begin
        in_ready  = 1'b0;
        busy      = 1'b0;
        beat      = 1'b0;
        last_beat = 1'b0;
        if (state == ACCUM) begin
            in_ready = 1'b1;
        end
        if (state != IDLE) begin
            busy = 1'b1;
        end
        beat      = in_valid && in_ready;
        last_beat = beat && (count == LAST_CNT);
    end

    // Running frame statistics and beat counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count   <= '0;
            run_min <= '1;
            run_max <= '0;
        end else if (state == IDLE && start) begin
            count   <= '0;
            run_min <= '1;
            run_max <= '0;
        end else if (beat) begin
            count   <= last_beat ? '0 : count + CNT_W'(1);
            if (in_i < run_min) run_min <= in_i;
            if (in_i > run_max) run_max <= in_i;
        end
    end

    // Midpoint of the frame range, summed one bit wider so it cannot overflow
    always_comb begin
        mid_sum = {1'b0, run_min} + {1'b0, run_max};
        mid     = WIDTH'(mid_sum >> 1);
    end

`ifdef THRESH_SMOOTH_EN
    logic [WIDTH:0] blend_sum;

    // Blend the midpoint with the current threshold
    always_comb begin
        blend_sum = {1'b0, threshold} + {1'b0, mid};
        thr_new   = WIDTH'(blend_sum >> 1);
    end
`else
    // Midpoint is used directly
    always_comb begin
        thr_new = mid;
    end
`endif

    // Threshold, statistics and update pulse, loaded on the UPDATE edge only
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            threshold <= INIT_THRESHOLD;
            thr_valid <= 1'b0;
            stat_min  <= '0;
            stat_max  <= '0;
        end else begin
            thr_valid <= (state == UPDATE);
            if (state == UPDATE) begin
                threshold <= thr_new;
                stat_min  <= run_min;
                stat_max  <= run_max;
            end
        end
    end

endmodule

// File: tb/tb_auto_threshold_ctrl.sv
// Bench for auto_threshold_ctrl: directed and randomized frames checked
// against a frame-level min/max/threshold model.
module tb_auto_threshold_ctrl;

    localparam int unsigned WIDTH   = 8;
    localparam int unsigned FRAME_W = 4;
    localparam int unsigned FRAME_H = 2;
    localparam int unsigned NPIX    = FRAME_W * FRAME_H;
    localparam int          INIT    = 128;

    logic             clk;
    logic             reset_n;
    logic             start;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_i;
    logic             busy;
    logic [WIDTH-1:0] threshold;
    logic             thr_valid;
    logic [WIDTH-1:0] stat_min;
    logic [WIDTH-1:0] stat_max;

    int n_checks = 0;
    int n_fail   = 0;
    int model_thr;
    int frame_vals [NPIX];

    auto_threshold_ctrl #(
        .WIDTH          (WIDTH),
        .FRAME_W        (FRAME_W),
        .FRAME_H        (FRAME_H),
        .INIT_THRESHOLD (8'(INIT))
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_i      (in_i),
        .busy      (busy),
        .threshold (threshold),
        .thr_valid (thr_valid),
        .stat_min  (stat_min),
        .stat_max  (stat_max)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_threshold"}, 32'(threshold), INIT);
        check({tag, "_in_ready"}, 32'(in_ready), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_thr_valid"}, 32'(thr_valid), 0);
        check({tag, "_stat_min"}, 32'(stat_min), 0);
        check({tag, "_stat_max"}, 32'(stat_max), 0);
    endtask

    // Frame-level reference: threshold from the min/max of the accepted samples
    function automatic int ref_threshold(input int prev, input int mn, input int mx);
        int m;
        m = (mn + mx) / 2;
`ifdef THRESH_SMOOTH_EN
        return (prev + m) / 2;
`else
        return m + 0 * prev;
`endif
    endfunction

    // One full frame from frame_vals. started: start already driven high by the
    // previous frame. chain: raise start in the thr_valid cycle for the next frame.
    task automatic run_frame(input string tag, input int vpct, input bit repulse,
                             input bit started, input bit chain);
        int beats = 0;
        int cyc   = 0;
        int mn    = 255;
        int mx    = 0;
        if (!started) begin
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        while (beats < int'(NPIX) && cyc < 300) begin
            in_valid = ($urandom_range(99) < 32'(vpct));
            in_i     = 8'(frame_vals[beats]);
            start    = repulse && ($urandom_range(2) == 0);
            check({tag, "_accum_ready"}, 32'(in_ready), 1);
            check({tag, "_accum_thr"}, 32'(threshold), model_thr);
            if (in_valid) begin
                if (frame_vals[beats] < mn) mn = frame_vals[beats];
                if (frame_vals[beats] > mx) mx = frame_vals[beats];
                beats++;
            end
            tick();
            cyc++;
        end
        if (cyc >= 300) check({tag, "_timeout"}, beats, int'(NPIX));
        in_valid = 1'b0;
        start    = 1'b0;
        // Update cycle: no more beats accepted, nothing visible yet
        check({tag, "_upd_ready"}, 32'(in_ready), 0);
        check({tag, "_upd_busy"}, 32'(busy), 1);
        check({tag, "_upd_thrv"}, 32'(thr_valid), 0);
        check({tag, "_upd_thr_hold"}, 32'(threshold), model_thr);
        model_thr = ref_threshold(model_thr, mn, mx);
        tick();
        check({tag, "_thr_valid"}, 32'(thr_valid), 1);
        check({tag, "_threshold"}, 32'(threshold), model_thr);
        check({tag, "_stat_min"}, 32'(stat_min), mn);
        check({tag, "_stat_max"}, 32'(stat_max), mx);
        check({tag, "_idle_busy"}, 32'(busy), 0);
        if (chain) start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_thrv_pulse"}, 32'(thr_valid), 0);
        check({tag, "_next_ready"}, 32'(in_ready), chain ? 1 : 0);
        check({tag, "_thr_after"}, 32'(threshold), model_thr);
    endtask

    task automatic load_frame(input int v0, input int v1, input int v2, input int v3,
                              input int v4, input int v5, input int v6, input int v7);
        frame_vals[0] = v0; frame_vals[1] = v1; frame_vals[2] = v2; frame_vals[3] = v3;
        frame_vals[4] = v4; frame_vals[5] = v5; frame_vals[6] = v6; frame_vals[7] = v7;
    endtask

    task automatic load_random();
        for (int i = 0; i < int'(NPIX); i++) frame_vals[i] = int'($urandom_range(255));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_i      = '0;
        model_thr = INIT;
        @(negedge clk);
        check_reset_state("in_reset");
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check_reset_state("idle5");

        // Reference frame, full rate; expected midpoint 105 (116 when smoothed)
        load_frame(10, 200, 50, 90, 30, 120, 60, 80);
        run_frame("frame_full", 100, 1'b0, 1'b0, 1'b0);
`ifdef THRESH_SMOOTH_EN
        check("ref_const", 32'(threshold), 116);
`else
        check("ref_const", 32'(threshold), 105);
`endif

        // Same frame with sparse valid and start re-pulsed mid-frame
        run_frame("frame_stall", 33, 1'b1, 1'b0, 1'b0);

        // Saturated and zero uniform frames
        load_frame(255, 255, 255, 255, 255, 255, 255, 255);
        run_frame("frame_255", 70, 1'b0, 1'b0, 1'b0);
        load_frame(0, 0, 0, 0, 0, 0, 0, 0);
        run_frame("frame_0", 70, 1'b0, 1'b0, 1'b0);

        // Reset after 5 beats: no update, reset values restored
        start = 1'b1;
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_i = 8'(i * 40 + 3);
            tick();
        end
        in_valid = 1'b0;
        reset_n  = 1'b0;
        model_thr = INIT;
        #1;
        check_reset_state("midreset");
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("midreset_no_thrv", 32'(thr_valid), 0);
        end
        check_reset_state("post_reset");
        load_frame(10, 200, 50, 90, 30, 120, 60, 80);
        run_frame("after_reset", 100, 1'b0, 1'b0, 1'b0);

        // Back-to-back frames with start in the thr_valid cycle
        load_frame(5, 6, 7, 8, 9, 10, 11, 12);
        run_frame("b2b_a", 100, 1'b0, 1'b0, 1'b1);
        load_frame(240, 250, 200, 220, 230, 210, 245, 201);
        run_frame("b2b_b", 100, 1'b0, 1'b1, 1'b1);
        load_random();
        run_frame("b2b_c", 60, 1'b0, 1'b1, 1'b0);

        // Randomized frames
        for (int f = 0; f < 20; f++) begin
            load_random();
            run_frame("rand", int'($urandom_range(100, 25)), f[0], 1'b0, 1'b0);
            for (int k = 0; k < int'($urandom_range(3)); k++) tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
